// File: rtl/cond_branch_pc.sv
// PC / conditional-branch stage: holds NZCV flags, resolves one branch per cycle,
// redirects the PC on taken branches and squashes the request in the following cycle.
module cond_branch_pc #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flags_we,
    input  logic             C,
    input  logic             N,
    input  logic             V,
    input  logic             Z,
    input  logic             step,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc,
    output logic [3:0]       flags,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [3:0]       flags_q, flags_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

    logic [3:0] eff;
    logic       e_n, e_z, e_c, e_v;
    logic       cond_true;
    logic       evaluated;
    logic       taken;

    // Same-cycle bypass so a branch can test flags written alongside it.
    assign eff = flags_we ? {N, Z, C, V} : flags_q;
    assign {e_n, e_z, e_c, e_v} = eff;

    always_comb begin
        cond_true = 1'b0;
        unique case (br_cond)
            4'h0: cond_true = e_z;
            4'h1: cond_true = ~e_z;
            4'h2: cond_true = e_c;
            4'h3: cond_true = ~e_c;
            4'h4: cond_true = e_n;
            4'h5: cond_true = ~e_n;
            4'h6: cond_true = e_v;
            4'h7: cond_true = ~e_v;
            4'h8: cond_true = e_c & ~e_z;
            4'h9: cond_true = ~e_c | e_z;
            4'hA: cond_true = (e_n == e_v);
            4'hB: cond_true = (e_n != e_v);
            4'hC: cond_true = ~e_z & (e_n == e_v);
            4'hD: cond_true = e_z | (e_n != e_v);
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // A request arriving in the shadow cycle is dropped entirely.
    assign evaluated = br_valid & ~flush_q;
    assign taken     = evaluated & cond_true;

    always_comb begin
        pc_d     = pc_q;
        flags_d  = flags_q;
        flush_d  = taken;
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (taken)
            pc_d = br_target;
        else if (step)
            pc_d = pc_q + WIDTH'(4);
        if (flags_we)
            flags_d = {N, Z, C, V};
        if (evaluated)
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (taken)
            tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            flags_q  <= 4'b0000;
            flush_q  <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            flush_q  <= flush_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign flags       = flags_q;
    assign flush       = flush_q;
    assign br_count    = br_cnt_q;
    assign taken_count = tk_cnt_q;

endmodule

// File: tb/tb_cond_branch_pc.sv
// Directed bench: a 32-bit instance for branch behaviour and an 8-bit/2-bit-counter
// instance for PC and counter wrap.
module tb_cond_branch_pc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // main instance
    logic        reset, flags_we, C, N, V, Z, step, br_valid;
    logic [3:0]  br_cond;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic        flush;
    logic [15:0] br_count, taken_count;

    cond_branch_pc #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flags_we(flags_we),
        .C(C), .N(N), .V(V), .Z(Z),
        .step(step), .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .pc(pc), .flags(flags), .flush(flush),
        .br_count(br_count), .taken_count(taken_count)
    );

    // small instance for wrap checks
    logic        s_reset, s_flags_we, s_C, s_N, s_V, s_Z, s_step, s_br_valid;
    logic [3:0]  s_br_cond;
    logic [7:0]  s_br_target;
    logic [7:0]  s_pc;
    logic [3:0]  s_flags;
    logic        s_flush;
    logic [1:0]  s_br_count, s_taken_count;

    cond_branch_pc #(.WIDTH(8), .RESET_PC(8'hF4), .CNT_W(2)) dut_s (
        .clk(clk), .reset(s_reset), .flags_we(s_flags_we),
        .C(s_C), .N(s_N), .V(s_V), .Z(s_Z),
        .step(s_step), .br_valid(s_br_valid), .br_cond(s_br_cond), .br_target(s_br_target),
        .pc(s_pc), .flags(s_flags), .flush(s_flush),
        .br_count(s_br_count), .taken_count(s_taken_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [31:0] e_pc, input logic e_flush,
                              input logic [15:0] e_br, input logic [15:0] e_tk);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".flush"}, 32'(flush), 32'(e_flush));
        check({tag, ".br_count"}, 32'(br_count), 32'(e_br));
        check({tag, ".taken_count"}, 32'(taken_count), 32'(e_tk));
    endtask

    initial begin
        reset = 1'b1; flags_we = 1'b0; {C, N, V, Z} = 4'b0; step = 1'b0;
        br_valid = 1'b0; br_cond = 4'h0; br_target = 32'h0;
        s_reset = 1'b1; s_flags_we = 1'b0; {s_C, s_N, s_V, s_Z} = 4'b0; s_step = 1'b0;
        s_br_valid = 1'b0; s_br_cond = 4'h0; s_br_target = 8'h0;
        #1;

        // reset state
        tick(); tick();
        reset = 1'b0;
        check_main("reset", 32'h0, 1'b0, 16'd0, 16'd0);
        check("reset.flags", 32'(flags), 32'h0);

        // step three times
        step = 1'b1;
        tick(); check("step1.pc", pc, 32'h4);
        tick(); check("step2.pc", pc, 32'h8);
        tick(); check("step3.pc", pc, 32'hC);

        // write N=1, V=0
        flags_we = 1'b1; N = 1'b1;
        tick();
        flags_we = 1'b0; N = 1'b0;
        check("fwr.pc", pc, 32'h10);
        check("fwr.flags", 32'(flags), 32'h8);

        // GE not taken, step advances
        br_valid = 1'b1; br_cond = 4'hA; br_target = 32'h100;
        tick();
        check_main("ge_nt", 32'h14, 1'b0, 16'd1, 16'd0);

        // LT taken, step ignored
        br_cond = 4'hB;
        tick();
        check_main("lt_t", 32'h100, 1'b1, 16'd2, 16'd1);

        // flush lasts one cycle
        br_valid = 1'b0; step = 1'b0;
        tick();
        check_main("lt_after", 32'h100, 1'b0, 16'd2, 16'd1);

        // same-cycle bypass: stored Z=0, write Z=1 with EQ branch
        flags_we = 1'b1; Z = 1'b1;
        br_valid = 1'b1; br_cond = 4'h0; br_target = 32'h40;
        tick();
        flags_we = 1'b0; Z = 1'b0; br_valid = 1'b0;
        check_main("bypass", 32'h40, 1'b1, 16'd3, 16'd2);
        check("bypass.flags", 32'(flags), 32'h4);
        tick();
        check("bypass_after.flush", 32'(flush), 32'h0);

        // shadow squash: AL to 0x80 then AL to 0x200 in the flush cycle
        step = 1'b1; br_valid = 1'b1; br_cond = 4'hE; br_target = 32'h80;
        tick();
        check_main("al1", 32'h80, 1'b1, 16'd4, 16'd3);
        br_target = 32'h200;
        tick();
        check_main("al_squash", 32'h84, 1'b0, 16'd4, 16'd3);

        // NV is evaluated but never taken
        step = 1'b0; br_cond = 4'hF; br_target = 32'h300;
        tick();
        check_main("nv", 32'h84, 1'b0, 16'd5, 16'd3);

        // LS with stored Z=1, C=0 -> taken
        br_cond = 4'h9; br_target = 32'h10;
        tick();
        br_valid = 1'b0;
        check_main("ls", 32'h10, 1'b1, 16'd6, 16'd4);
        tick();

        // HI with Z=1 -> not taken
        br_valid = 1'b1; br_cond = 4'h8; br_target = 32'h500;
        tick();
        br_valid = 1'b0;
        check_main("hi_nt", 32'h10, 1'b0, 16'd7, 16'd4);

        // reset asserted during the flush cycle
        br_valid = 1'b1; br_cond = 4'hE; br_target = 32'h300;
        tick();
        check_main("pre_rst", 32'h300, 1'b1, 16'd8, 16'd5);
        reset = 1'b1; step = 1'b1; br_target = 32'h400;
        flags_we = 1'b1; N = 1'b1; C = 1'b1;
        tick();
        reset = 1'b0; step = 1'b0; br_valid = 1'b0; flags_we = 1'b0; N = 1'b0; C = 1'b0;
        check_main("mid_rst", 32'h0, 1'b0, 16'd0, 16'd0);
        check("mid_rst.flags", 32'(flags), 32'h0);

        // small instance: PC wrap from 0xFC
        s_reset = 1'b0;
        check("s_reset.pc", 32'(s_pc), 32'hF4);
        s_step = 1'b1;
        tick(); tick();
        check("s_pre.pc", 32'(s_pc), 32'hFC);
        tick();
        check("s_wrap.pc", 32'(s_pc), 32'h00);
        s_step = 1'b0;

        // five taken branches, two cycles apart -> taken_count wraps to 1
        for (int i = 0; i < 5; i++) begin
            s_br_valid = 1'b1; s_br_cond = 4'hE; s_br_target = 8'(8'h20 + 8'(i));
            tick();
            s_br_valid = 1'b0;
            tick();
        end
        check("s_cnt.taken", 32'(s_taken_count), 32'h1);
        check("s_cnt.br", 32'(s_br_count), 32'h1);
        check("s_cnt.pc", 32'(s_pc), 32'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_branch_pc.md
# cond_branch_pc

Program-counter and conditional-branch stage that sits directly downstream of the ALU flag outputs. It holds the architectural NZCV flag register and evaluates a 4-bit condition code against it, using the same HS/LS/HI/LO/GE/LE/GT/LT relations the comparison-flag decoder produces. It redirects the PC on taken branches and keeps branch statistics. One branch can be resolved per cycle, with a single-cycle squash shadow after each taken branch.

## Interface
Parameters:
- WIDTH, 32, PC and branch-target width
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flags_we  in  1  write C,N,V,Z into the flag register this cycle
- C, N, V, Z  in  1 each  flag values from the ALU
- step  in  1  advance PC by 4 this cycle
- br_valid  in  1  branch request present this cycle
- br_cond  in  4  condition code of the request
- br_target  in  WIDTH  branch destination
- pc  out  WIDTH  current program counter
- flags  out  4  stored flags, ordered {N,Z,C,V}
- flush  out  1  high for exactly one cycle after a taken branch
- br_count  out  CNT_W  number of evaluated branches
- taken_count  out  CNT_W  number of taken branches

## Operation
- Condition codes: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Effective flags (eff): the incoming C,N,V,Z when flags_we=1, otherwise the stored register (same-cycle bypass).
- Evaluated branch: br_valid=1 and flush=0. cond_true is the br_cond function applied to eff.
- Squashed request: br_valid=1 while flush=1. It is not evaluated, does not change the counters and does not redirect the PC.
- PC next-state, in priority order:
  1. reset gives RESET_PC.
  2. An evaluated branch with cond_true gives br_target, unmodified with no alignment.
  3. step gives pc+4, modulo 2^WIDTH (wraps).
  4. Otherwise pc holds.
- Flag register: loads {N,Z,C,V} when flags_we=1, otherwise holds.
- flush next = evaluated & cond_true.
- br_count increments on each evaluated branch. taken_count increments on each taken branch. Both wrap modulo 2^CNT_W.
- A flag write with no branch in the same cycle only updates the register.

## Timing
- Reset values: pc=RESET_PC, flags=4'b0000, flush=0, br_count=0, taken_count=0.
- Reset dominates all other inputs in the same cycle. An in-flight shadow is cancelled, so flush is 0 after the reset edge.
- Branch resolution has zero cycles of decision latency: the request is evaluated combinationally in cycle t. The new pc and flush=1 are visible after the edge that ends cycle t.
- flush lasts exactly one cycle. A request in that cycle is squashed even if it is AL.
- Back-to-back: a branch in cycle t+2 after a taken branch at t is evaluated normally.
- step together with a taken branch: the branch wins and step is ignored. step together with a not-taken branch gives pc+4.
- Flag-register outputs show the new value one cycle after flags_we.

## Test plan
- Reset then step for 3 cycles -> pc 0, 4, 8, 12. flags=0. Counters 0.
- flags_we with N=1,V=0 (other flags 0), then a GE branch to 0x100 next cycle -> not taken, pc advances by step, br_count=1, taken_count=0. An LT branch to 0x100 -> pc=0x100, flush=1 for one cycle, taken_count=1.
- Same-cycle bypass: stored Z=0, flags_we with Z=1, and an EQ branch to 0x40 in the same cycle -> taken, pc=0x40.
- Shadow squash: AL branch to 0x80, then an AL branch to 0x200 in the next cycle -> pc=0x80. The second request is squashed, br_count rises by 1 only, and pc continues 0x84 if step=1.
- Wrap: WIDTH=8, pc=0xFC with step -> pc=0x00. CNT_W=2 with 5 taken branches spaced by 2 cycles -> taken_count=1.
- Reset mid-shadow: a taken branch, then reset asserted during the flush cycle -> pc=RESET_PC, flush=0, counters 0 on the next cycle.
